// File: rtl/sram_like_arbiter.sv
// Two-master (fetch/data) arbiter onto one SRAM-like port. Responses are routed
// back through an in-order ID FIFO; data has priority with a fetch starvation guard.
module sram_like_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       inst_req,
  input  logic                       inst_wr,
  input  logic [1:0]                 inst_size,
  input  logic [3:0]                 inst_wstrb,
  input  logic [31:0]                inst_addr,
  input  logic [31:0]                inst_wdata,
  output logic                       inst_addr_ok,
  output logic                       inst_data_ok,
  output logic [31:0]                inst_rdata,
  input  logic                       data_req,
  input  logic                       data_wr,
  input  logic [1:0]                 data_size,
  input  logic [3:0]                 data_wstrb,
  input  logic [31:0]                data_addr,
  input  logic [31:0]                data_wdata,
  output logic                       data_addr_ok,
  output logic                       data_data_ok,
  output logic [31:0]                data_rdata,
  output logic                       mem_req,
  output logic                       mem_wr,
  output logic [1:0]                 mem_size,
  output logic [3:0]                 mem_wstrb,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  input  logic                       mem_addr_ok,
  input  logic                       mem_data_ok,
  input  logic [31:0]                mem_rdata,
  output logic [$clog2(DEPTH):0]     outstanding,
  output logic                       proto_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = 8;

  typedef enum logic {ID_INST = 1'b0, ID_DATA = 1'b1} id_t;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  id_t           fifo [DEPTH];
  logic          lock_valid;
  id_t           lock_id;
  logic [SW-1:0] starve_cnt;

  logic full, empty, locked_req, violation, grant_valid, accept, pop;
  id_t  grant, head;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign locked_req = (lock_id == ID_INST) ? inst_req : data_req;
  assign violation  = lock_valid & ~locked_req;

  // A held request keeps the grant until accepted, regardless of priority.
  always_comb begin
    grant_valid = 1'b0;
    grant       = ID_INST;
    if (lock_valid) begin
      grant       = lock_id;
      grant_valid = locked_req;
    end else if (!full) begin
      if (starve_cnt == SW'(STARVE_LIMIT) && inst_req) begin
        grant       = ID_INST;
        grant_valid = 1'b1;
      end else if (data_req) begin
        grant       = ID_DATA;
        grant_valid = 1'b1;
      end else if (inst_req) begin
        grant       = ID_INST;
        grant_valid = 1'b1;
      end
    end
  end

  assign mem_req   = grant_valid & ~full;
  assign mem_wr    = (grant == ID_DATA) ? data_wr    : inst_wr;
  assign mem_size  = (grant == ID_DATA) ? data_size  : inst_size;
  assign mem_wstrb = (grant == ID_DATA) ? data_wstrb : inst_wstrb;
  assign mem_addr  = (grant == ID_DATA) ? data_addr  : inst_addr;
  assign mem_wdata = (grant == ID_DATA) ? data_wdata : inst_wdata;

  assign accept       = mem_req & mem_addr_ok;
  assign inst_addr_ok = accept & (grant == ID_INST);
  assign data_addr_ok = accept & (grant == ID_DATA);

  // A response with nothing outstanding is dropped, never popped.
  assign pop          = mem_data_ok & ~empty;
  assign head         = fifo[rd_ptr];
  assign inst_data_ok = pop & (head == ID_INST);
  assign data_data_ok = pop & (head == ID_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign outstanding  = count;

  always_ff @(posedge clk) begin
    if (accept) fifo[wr_ptr] <= grant;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      lock_valid <= 1'b0;
      lock_id    <= ID_INST;
      starve_cnt <= '0;
      proto_err  <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // While full no new lock forms; an existing one is held for reissue.
      if (violation) begin
        lock_valid <= 1'b0;
      end else if (mem_req && !mem_addr_ok) begin
        lock_valid <= 1'b1;
        lock_id    <= grant;
      end else if (accept) begin
        lock_valid <= 1'b0;
      end

      if (violation || (mem_data_ok && empty)) proto_err <= 1'b1;

      if (!inst_req || inst_addr_ok)
        starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one downstream SRAM-like memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage).
- Sits between the pipeline stages and the SRAM-to-AXI bridge.
- Issues one request per addr_ok handshake and tracks outstanding requests in order with an ID FIFO, so each data_ok returns to the master that issued the request.
- Data port has priority over fetch; a starvation guard prevents fetch from being locked out indefinitely.

Parameters:
- DEPTH, 4, maximum outstanding requests (ID FIFO depth, power of 2, 2..16)
- STARVE_LIMIT, 8, consecutive denied inst cycles before inst wins arbitration (1..255)

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- inst_req / inst_wr  in  1 / 1  fetch request / write flag
- inst_size  in  2  access size
- inst_wstrb  in  4  byte strobes
- inst_addr / inst_wdata  in  32 / 32  fetch address / write data
- inst_addr_ok / inst_data_ok  out  1 / 1  fetch handshakes
- inst_rdata  out  32  read data
- data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  1,1,2,4,32,32  data-side request, same meanings as inst_*
- data_addr_ok / data_data_ok  out  1 / 1  data handshakes
- data_rdata  out  32  read data
- mem_req / mem_wr  out  1 / 1  downstream request / write flag
- mem_size  out  2  access size
- mem_wstrb  out  4  byte strobes
- mem_addr / mem_wdata  out  32 / 32  downstream address / write data
- mem_addr_ok / mem_data_ok  in  1 / 1  downstream handshakes
- mem_rdata  in  32  downstream read data
- outstanding  out  log2(DEPTH)+1  current FIFO occupancy
- proto_err  out  1  sticky protocol-error flag

Behaviour:
- Handshake: a request is accepted in a cycle with mem_req & mem_addr_ok. A response completes in a cycle with mem_data_ok. Responses arrive strictly in acceptance order, earliest one cycle after acceptance.
- Grant, combinational, evaluated only when unlocked and FIFO not full:
  - starve_cnt == STARVE_LIMIT and inst_req: grant inst.
  - Otherwise data_req: grant data.
  - Otherwise inst_req: grant inst.
  - Otherwise no request.
- mem_req = granted master's req & !full. mem_* request fields mux from the granted master.
- Lock: if mem_req & !mem_addr_ok, register lock_valid=1 and lock_id=grant. While locked, grant = lock_id regardless of priority or starvation. The lock clears on the accepting cycle.
  - If the locked master drops req (violation): mem_req is 0 that cycle, the lock clears, and proto_err is set.
- Per-master addr_ok: inst_addr_ok = mem_addr_ok & mem_req & grant==inst. data_addr_ok is analogous. Combinational, zero added latency.
- ID FIFO: push the grant id on acceptance; pop on mem_data_ok.
  - inst_data_ok = mem_data_ok & head==inst; data_data_ok analogous.
  - inst_rdata = data_rdata = mem_rdata, passed through unregistered.
- Full: occupancy == DEPTH forces mem_req=0. The lock is retained; a locked request is reissued once a slot frees.
- Simultaneous push and pop: occupancy unchanged. The pointers wrap modulo DEPTH.
- mem_data_ok with an empty FIFO, including the same cycle as the first push: the response is dropped, both data_ok outputs are 0, proto_err=1, and the FIFO is unchanged.
- starve_cnt, saturating at STARVE_LIMIT:
  - Clears when inst_req is 0 or an inst request is accepted.
  - Otherwise increments each cycle inst_req is 1 and inst is not accepted.
- Reset, when resetn=0 at a clk edge, including mid-transaction:
  - FIFO pointers/count = 0, lock_valid = 0, starve_cnt = 0, proto_err = 0.
  - The downstream slave must be reset concurrently.
  - After reset all outputs are 0 (mem_req=0, outstanding=0, all addr_ok/data_ok=0). mem_addr/rdata buses follow their combinational sources.

Test Plan:
- Reset, both masters idle -> mem_req=0, outstanding=0, proto_err=0. Then inst_req with inst_addr=0x1c000000, mem_addr_ok=1 -> mem_addr=0x1c000000, inst_addr_ok=1. Next cycle mem_data_ok=1 with rdata=0x02800000 -> inst_data_ok=1, data_data_ok=0.
- Both masters request every cycle, slave always ready, STARVE_LIMIT=8 -> 8 consecutive data accepts, then 1 inst accept, pattern repeats. outstanding never exceeds DEPTH.
- Slave holds mem_addr_ok=0 for 3 cycles while inst is granted, then data_req rises -> mem_addr stays the inst address until accepted. The data request is accepted the following cycle.
- Issue 4 requests (I,D,I,D) with no data_ok -> outstanding=4, mem_req=0 despite pending req. Then 4 data_ok pulses -> data_ok routed I,D,I,D; outstanding returns to 0. Repeat past the wrap point.
- mem_data_ok=1 with outstanding=0 -> no data_ok to either master, proto_err=1 and held until reset.
- Assert resetn=0 with 3 outstanding and a lock active -> next cycle outstanding=0, mem_req=0. A new inst request is accepted normally.
